audio_dac_tx: RTL and testbench
===============================

AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

Interface
REQ-001 SHALL have parameter SAMPLE_W, 24, bits per audio sample (8..32).
REQ-002 SHALL have parameter SLOT_W, 32, BCLK periods per channel slot; elaboration error unless SLOT_W >= SAMPLE_W+1.
REQ-003 SHALL have parameter BCLK_DIV, 2, clk cycles per BCLK half-period (>=1).
REQ-004 SHALL have parameter FIFO_DEPTH, 8, stereo-pair FIFO entries; elaboration error unless power of 2 and >=2.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports en (in, 1, serializer run) and mode (in, 1, 0=left-justified, 1=I2S).
REQ-008 SHALL have ports s_valid (in, 1), s_ready (out, 1), s_left and s_right (in, SAMPLE_W each, two's-complement), together forming the sample-pair stream.
REQ-009 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-010 SHALL have ports underrun (out, 1, sticky) and underrun_clr (in, 1).
REQ-011 SHALL have ports aud_bclk, aud_daclrck and aud_dacdat (out, 1 each, DAC serial bus).

Function
REQ-012 SHALL transfer a pair on every clk edge where s_valid and s_ready are both 1; s_ready = not full, with no same-cycle bypass when full and popping.
REQ-013 While en=1, SHALL count clk cycles 0..BCLK_DIV-1 and toggle aud_bclk at each wrap; BCLK period = 2*BCLK_DIV clk cycles.
REQ-014 SHALL update aud_dacdat and aud_daclrck only in the clk cycle in which aud_bclk goes 1->0; all three bus outputs are registered.
REQ-015 Frame = left slot (aud_daclrck=0) then right slot (aud_daclrck=1), each SLOT_W BCLK periods; slot bit position p = 0..SLOT_W-1.
REQ-016 Left-justified: bit at p = sample[SAMPLE_W-1-p] for p < SAMPLE_W, else 0.
REQ-017 I2S: bit at p = 0 for p=0, sample[SAMPLE_W-p] for 1 <= p <= SAMPLE_W, else 0.
REQ-018 At each frame boundary (falling edge that starts left p=0), SHALL pop one pair and sample mode; mode changes mid-frame take effect only at the next boundary.
REQ-019 FIFO empty at a boundary: SHALL serialize zeros for that whole frame and set underrun; a pair arriving mid-frame waits for the next boundary.
REQ-020 underrun_clr SHALL clear underrun; a simultaneous set wins.
REQ-021 en 1->0: next cycle SHALL force aud_bclk=0, aud_daclrck=0, aud_dacdat=0, zero all counters; no pop; FIFO keeps accepting.
REQ-022 en 0->1: first aud_bclk rise after BCLK_DIV cycles; first frame boundary on the following fall, popping the head pair.

Reset
REQ-023 Reset SHALL empty the FIFO and set s_ready=1 when reset is low the next cycle, fifo_level=0, underrun=0, aud_bclk=0, aud_daclrck=0, aud_dacdat=0, counters=0; reset overrides en and all handshakes, mid-frame included.

Configuration
REQ-024 With AUDIO_DAC_TX_DEBUG_EN defined, SHALL add outputs debug_daclrck and debug_dacdat, identical copies of aud_daclrck and aud_dacdat; without it those ports and logic SHALL not exist and function is unchanged.

Structure
REQ-025 Package audio_pkg SHALL hold the mode encoding (AUD_MODE_LJ=0, AUD_MODE_I2S=1) and the parameter-legality check constants.
REQ-026 SHALL instantiate one sub-module, audio_sample_fifo (synchronous show-ahead FIFO, width 2*SAMPLE_W, depth FIFO_DEPTH, level output).

Verification (SAMPLE_W=16, SLOT_W=32, BCLK_DIV=2; frame = 256 clk)
REQ-027 LJ, push L=0x8001 R=0x7FFE, en=1 -> left slot bits 1000000000000001 then 16 zeros, lrck=0; right slot 0111111111111110 then zeros, lrck=1.
REQ-028 I2S, same pair -> left slot 0, 1000000000000001, 15 zeros; MSB on second BCLK after lrck edge.
REQ-029 Push 9 pairs with en=0 -> first 8 accepted, s_ready=0 on 9th, fifo_level=8; en=1 -> level drops by 1 per 256 clk.
REQ-030 en=1, FIFO empty -> frame all zeros, underrun=1; underrun_clr together with next empty boundary -> underrun stays 1.
REQ-031 Reset asserted at left p=10 -> next cycle all bus outputs 0, fifo_level=0, s_ready=1 after release; mode toggled mid-frame applies only from next boundary.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg -- shared definitions for the audio DAC transmitter.
//   * Mode encoding for the serial format (left-justified / I2S).
//   * Legal ranges for the transmitter parameters.
//   * aud_slot_bit(): the data bit carried at a given slot position.
package audio_pkg;

    localparam logic AUD_MODE_LJ  = 1'b0;
    localparam logic AUD_MODE_I2S = 1'b1;

    localparam int AUD_SAMPLE_W_MIN   = 8;
    localparam int AUD_SAMPLE_W_MAX   = 32;
    localparam int AUD_SLOT_MARGIN    = 1;   // SLOT_W must be >= SAMPLE_W + this
    localparam int AUD_BCLK_DIV_MIN   = 1;
    localparam int AUD_FIFO_DEPTH_MIN = 2;

    function automatic bit aud_is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Bit at slot position pos for a sample right-aligned in 32 bits.
    // LJ puts the MSB at pos 0; I2S delays it by one BCLK.
    function automatic logic aud_slot_bit(input logic [31:0]  sample,
                                          input int unsigned  sample_w,
                                          input int unsigned  pos,
                                          input logic         mode);
        logic [31:0] shifted;
        shifted = '0;
        if (mode == AUD_MODE_LJ) begin
            if (pos < sample_w) begin
                shifted = sample >> (sample_w - 1 - pos);
            end
        end else begin
            if ((pos >= 1) && (pos <= sample_w)) begin
                shifted = sample >> (sample_w - pos);
            end
        end
        return shifted[0];
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo -- synchronous show-ahead FIFO holding stereo pairs.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (empties FIFO)
//   push, wdata        : write request and data (ignored when full)
//   pop                : read request (ignored when empty)
//   rdata              : head entry, valid whenever empty=0
//   empty, full, level : occupancy status
module audio_sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx -- stereo sample-pair FIFO feeding a DAC serial bus
// (BCLK / LRCK / DATA) in left-justified or I2S format.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   en                    : serializer run; low forces the bus idle
//   mode                  : 0 = left-justified, 1 = I2S (taken at frame start)
//   s_valid/s_ready       : pair handshake, transfer when both are 1
//   s_left, s_right       : two's-complement samples of the pair
//   fifo_level            : occupied FIFO entries
//   underrun, underrun_clr: sticky "empty at frame start" flag and its clear
//   aud_bclk, aud_daclrck, aud_dacdat : registered DAC serial bus
// Build option: define AUDIO_DAC_TX_DEBUG_EN to add debug_daclrck and
// debug_dacdat, copies of aud_daclrck and aud_dacdat.
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int BCLK_DIV   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          mode,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_W-1:0]           s_left,
    input  logic [SAMPLE_W-1:0]           s_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic                          aud_bclk,
    output logic                          aud_daclrck,
    output logic                          aud_dacdat
`ifdef AUDIO_DAC_TX_DEBUG_EN
    ,
    output logic                          debug_daclrck,
    output logic                          debug_dacdat
`endif
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int POS_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(BCLK_DIV + 1);

    if ((SAMPLE_W < AUD_SAMPLE_W_MIN) || (SAMPLE_W > AUD_SAMPLE_W_MAX)) begin : g_bad_sample_w
        $error("audio_dac_tx: SAMPLE_W out of range");
    end
    if (SLOT_W < SAMPLE_W + AUD_SLOT_MARGIN) begin : g_bad_slot_w
        $error("audio_dac_tx: SLOT_W must be at least SAMPLE_W+1");
    end
    if (BCLK_DIV < AUD_BCLK_DIV_MIN) begin : g_bad_bclk_div
        $error("audio_dac_tx: BCLK_DIV must be at least 1");
    end
    if (!aud_is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < AUD_FIFO_DEPTH_MIN)) begin : g_bad_depth
        $error("audio_dac_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    // ---------------- sample FIFO ----------------
    logic [2*SAMPLE_W-1:0] head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    // Ready depends only on full: a pop in the same cycle does not open a slot.
    assign s_ready = !fifo_full;
    assign push    = s_valid && s_ready;

    audio_sample_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({s_left, s_right}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // ---------------- bit clock and frame position ----------------
    logic [DIV_W-1:0] div_cnt;
    // Position of the bit to be driven at the next BCLK fall; 0 means the
    // next fall starts a new frame (left slot, p=0).
    logic [POS_W-1:0] next_pos;
    logic             wrap;
    logic             fall;
    logic             boundary;

    assign wrap     = en && (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall     = wrap && aud_bclk;
    assign boundary = fall && (next_pos == '0);
    assign pop      = boundary && !fifo_empty;

    // Pair and mode serialized during the current frame.
    logic [SAMPLE_W-1:0] frm_l;
    logic [SAMPLE_W-1:0] frm_r;
    logic                frm_mode;

    logic [SAMPLE_W-1:0] cur_l;
    logic [SAMPLE_W-1:0] cur_r;
    logic                cur_mode;
    logic [SAMPLE_W-1:0] smp;
    logic [POS_W-1:0]    slot_pos;
    logic                in_right;
    logic                next_bit;

    // At a boundary the first bit already belongs to the new frame, so the
    // FIFO head (or zeros on underrun) and the live mode are used directly.
    always_comb begin
        cur_l    = frm_l;
        cur_r    = frm_r;
        cur_mode = frm_mode;
        if (boundary) begin
            cur_l    = fifo_empty ? '0 : head[2*SAMPLE_W-1 -: SAMPLE_W];
            cur_r    = fifo_empty ? '0 : head[SAMPLE_W-1:0];
            cur_mode = mode;
        end
        in_right = 1'b0;
        slot_pos = next_pos;
        smp      = cur_l;
        if (next_pos >= POS_W'(SLOT_W)) begin
            in_right = 1'b1;
            slot_pos = next_pos - POS_W'(SLOT_W);
            smp      = cur_r;
        end
        next_bit = aud_slot_bit(32'(smp), SAMPLE_W, 32'(slot_pos), cur_mode);
    end

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt     <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            next_pos    <= '0;
        end else begin
            if (wrap) begin
                div_cnt  <= '0;
                aud_bclk <= !aud_bclk;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end
            if (fall) begin
                aud_daclrck <= in_right;
                aud_dacdat  <= next_bit;
                if (next_pos == POS_W'(FRAME_BITS - 1)) begin
                    next_pos <= '0;
                end else begin
                    next_pos <= next_pos + POS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frm_l    <= '0;
            frm_r    <= '0;
            frm_mode <= AUD_MODE_LJ;
        end else if (boundary) begin
            frm_l    <= cur_l;
            frm_r    <= cur_r;
            frm_mode <= cur_mode;
        end
    end

    // Setting on an empty boundary takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (boundary && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

`ifdef AUDIO_DAC_TX_DEBUG_EN
    assign debug_daclrck = aud_daclrck;
    assign debug_dacdat  = aud_dacdat;
`endif

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx -- bench for audio_dac_tx (SAMPLE_W=16, SLOT_W=32,
// BCLK_DIV=2, FIFO_DEPTH=8). Reference model: a queue of pushed pairs and
// arithmetic on the number of enabled clk cycles to locate BCLK edges,
// frame boundaries and the slot bit on the bus.
module tb_audio_dac_tx;

    localparam int SAMPLE_W       = 16;
    localparam int SLOT_W         = 32;
    localparam int BCLK_DIV       = 2;
    localparam int FIFO_DEPTH     = 8;
    localparam int FRAME_BITS     = 2 * SLOT_W;
    localparam int FRAME_CLK      = 2 * BCLK_DIV * FRAME_BITS;
    localparam int BOUNDARY_PHASE = 2 * BCLK_DIV - 1;

    // ---------------- clock / reset / DUT ----------------
    logic clk;
    logic reset, en, mode, s_valid, s_ready, underrun, underrun_clr;
    logic aud_bclk, aud_daclrck, aud_dacdat;
    logic [SAMPLE_W-1:0] s_left, s_right;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
`ifdef AUDIO_DAC_TX_DEBUG_EN
    logic debug_daclrck, debug_dacdat;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    audio_dac_tx #(
        .SAMPLE_W   (SAMPLE_W),
        .SLOT_W     (SLOT_W),
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .aud_bclk     (aud_bclk),
        .aud_daclrck  (aud_daclrck),
        .aud_dacdat   (aud_dacdat)
`ifdef AUDIO_DAC_TX_DEBUG_EN
        ,
        .debug_daclrck (debug_daclrck),
        .debug_dacdat  (debug_dacdat)
`endif
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model state ----------------
    logic [2*SAMPLE_W-1:0] exp_q[$];
    int   en_cycles;
    int   m_f;
    bit   m_rise;
    logic [SAMPLE_W-1:0] mf_l, mf_r;
    logic mf_mode;
    logic exp_underrun, exp_bclk, exp_lrck, exp_dat;
    int   n_compared;
    int   n_mismatched;
    logic [63:0] cap_dat, cap_lrck;
    int   cap_cnt;
    bit   cap_armed;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_slot_bit(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r,
                                          input logic m, input int q);
        logic [SAMPLE_W-1:0] s;
        logic [SAMPLE_W-1:0] sh;
        int p;
        s  = (q < SLOT_W) ? l : r;
        p  = q % SLOT_W;
        sh = '0;
        if (m == 1'b0) begin
            if (p < SAMPLE_W) sh = s >> (SAMPLE_W - 1 - p);
        end else begin
            if (p >= 1 && p <= SAMPLE_W) sh = s >> (SAMPLE_W - p);
        end
        return sh[0];
    endfunction

    // Advance the model by one clk edge using the inputs held across it.
    task automatic model_edge();
        int pre_size, c, t, q;
        bit boundary;
        logic [2*SAMPLE_W-1:0] pair;
        pre_size = exp_q.size();
        boundary = 0;
        m_rise   = 0;
        if (reset) begin
            exp_q.delete();
            exp_underrun = 0;
            en_cycles = 0;
            m_f = 0;
            exp_bclk = 0;
            exp_lrck = 0;
            exp_dat  = 0;
            return;
        end
        if (en) begin
            c = en_cycles;
            t = (c + 1) / BCLK_DIV;     // BCLK toggles so far
            m_f = t / 2;                // BCLK falls so far
            if ((c + 1) % BCLK_DIV == 0) begin
                if (t % 2 == 1) m_rise = 1;
                else if ((m_f - 1) % FRAME_BITS == 0) boundary = 1;
            end
            en_cycles++;
            exp_bclk = ((t % 2) == 1);
        end else begin
            en_cycles = 0;
            m_f = 0;
            exp_bclk = 0;
        end
        if (boundary) begin
            if (pre_size > 0) begin
                pair = exp_q.pop_front();
                mf_l = pair[2*SAMPLE_W-1:SAMPLE_W];
                mf_r = pair[SAMPLE_W-1:0];
            end else begin
                mf_l = '0;
                mf_r = '0;
            end
            mf_mode = mode;
        end
        if (boundary && pre_size == 0) exp_underrun = 1;
        else if (underrun_clr) exp_underrun = 0;
        if (s_valid && pre_size < FIFO_DEPTH) exp_q.push_back({s_left, s_right});
        if (m_f == 0) begin
            exp_lrck = 0;
            exp_dat  = 0;
        end else begin
            q = (m_f - 1) % FRAME_BITS;
            exp_lrck = (q >= SLOT_W);
            exp_dat  = exp_slot_bit(mf_l, mf_r, mf_mode, q);
        end
    endtask

    task automatic check_outputs();
        check_eq("bclk", aud_bclk, exp_bclk);
        check_eq("lrck", aud_daclrck, exp_lrck);
        check_eq("dacdat", aud_dacdat, exp_dat);
        check_eq("s_ready", s_ready, (exp_q.size() < FIFO_DEPTH));
        check_eq("fifo_level", fifo_level, exp_q.size());
        check_eq("underrun", underrun, exp_underrun);
`ifdef AUDIO_DAC_TX_DEBUG_EN
        check_eq("debug_lrck", debug_daclrck, exp_lrck);
        check_eq("debug_dat", debug_dacdat, exp_dat);
`endif
    endtask

    // One clock: model update, check away from the edge, optional capture.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (cap_armed && m_rise && m_f >= 1 && cap_cnt < FRAME_BITS) begin
            cap_dat  = {cap_dat[62:0], aud_dacdat};
            cap_lrck = {cap_lrck[62:0], aud_daclrck};
            cap_cnt++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
        step();
    endtask

    task automatic push_pair(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
        s_valid = 1;
        s_left  = l;
        s_right = r;
        step();
        s_valid = 0;
    endtask

    task automatic arm_capture();
        cap_armed = 1;
        cap_cnt   = 0;
        cap_dat   = '0;
        cap_lrck  = '0;
    endtask

    // Step until the bus shows frame fi, position q (bounded).
    task automatic wait_pos(input int fi, input int q, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 4 * FRAME_CLK && !found; i++) begin
            if (m_f >= 1 && (m_f - 1) / FRAME_BITS == fi && (m_f - 1) % FRAME_BITS == q) found = 1;
            else step();
        end
        check_eq(tag, found, 1);
    endtask

    // Step until the next edge is a frame boundary (bounded).
    task automatic wait_before_boundary(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < FRAME_CLK + 1 && !found; i++) begin
            if (en_cycles % FRAME_CLK == BOUNDARY_PHASE) found = 1;
            else step();
        end
        check_eq(tag, found, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rst_at, off_cnt, pm;
        n_compared = 0;
        n_mismatched = 0;
        cap_armed = 0;
        cap_cnt = 0;
        mf_l = '0; mf_r = '0; mf_mode = 0;
        en_cycles = 0; m_f = 0;
        exp_underrun = 0; exp_bclk = 0; exp_lrck = 0; exp_dat = 0;
        reset = 1; en = 0; mode = 0; s_valid = 0; s_left = '0; s_right = '0; underrun_clr = 0;

        // Reset state
        run(3);
        reset = 0;
        step();

        // Fill with en=0: eight accepted, ninth refused
        for (int i = 0; i < 9; i++) begin
            s_valid = 1;
            s_left  = (i == 0) ? 16'h8001 : 16'($urandom);
            s_right = (i == 0) ? 16'h7FFE : 16'($urandom);
            step();
        end
        s_valid = 0;
        check_eq("full_level", fifo_level, 8);
        check_eq("full_ready", s_ready, 0);

        // Left-justified frames, one pop per frame
        arm_capture();
        mode = 0;
        en = 1;
        run(FRAME_CLK);
        check_eq("level_frame1", fifo_level, 7);
        run(FRAME_CLK);
        check_eq("level_frame2", fifo_level, 6);
        run(FRAME_CLK);
        check_eq("level_frame3", fifo_level, 5);
        check_eq("lj_cap_count", cap_cnt, FRAME_BITS);
        check_eq("lj_left_slot", cap_dat[63:32], 32'h8001_0000);
        check_eq("lj_right_slot", cap_dat[31:0], 32'h7FFE_0000);
        check_eq("lj_lrck", cap_lrck, 64'h0000_0000_FFFF_FFFF);
        cap_armed = 0;
        en = 0;
        step();
        check_eq("disable_bus", {aud_bclk, aud_daclrck, aud_dacdat}, 3'b000);

        // I2S frame, then empty frames and underrun
        do_reset();
        mode = 1;
        push_pair(16'h8001, 16'h7FFE);
        arm_capture();
        en = 1;
        run(2 * FRAME_CLK);
        check_eq("i2s_left_slot", cap_dat[63:32], 32'h4000_8000);
        check_eq("i2s_right_slot", cap_dat[31:0], 32'h3FFF_0000);
        check_eq("i2s_lrck", cap_lrck, 64'h0000_0000_FFFF_FFFF);
        check_eq("underrun_set", underrun, 1);
        cap_armed = 0;
        wait_before_boundary("boundary_found");
        underrun_clr = 1;
        step();
        underrun_clr = 0;
        check_eq("clr_vs_set", underrun, 1);
        underrun_clr = 1;
        step();
        underrun_clr = 0;
        check_eq("clr_alone", underrun, 0);

        // Mid-frame mode change, then reset at left p=10
        en = 0;
        do_reset();
        mode = 0;
        for (int i = 0; i < 3; i++) push_pair(16'($urandom), 16'($urandom));
        en = 1;
        wait_pos(0, 20, "reach_f0_p20");
        mode = 1;
        wait_pos(1, 10, "reach_f1_p10");
        reset = 1;
        step();
        check_eq("rst_bus", {aud_bclk, aud_daclrck, aud_dacdat}, 3'b000);
        check_eq("rst_level", fifo_level, 0);
        reset = 0;
        step();
        check_eq("rst_ready", s_ready, 1);
        check_eq("rst_underrun", underrun, 0);

        // Randomized traffic
        rst_at  = $urandom_range(1000, 6000);
        off_cnt = 0;
        pm      = 300;
        for (int c = 0; c < 30 * FRAME_CLK; c++) begin
            if (c % 1024 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pm = 0;
                    1:       pm = 5;
                    default: pm = 300;
                endcase
            end
            s_valid = ($urandom_range(0, 999) < pm);
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            underrun_clr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 399) == 0) mode = ~mode;
            if (off_cnt > 0) begin
                off_cnt--;
                en = (off_cnt == 0);
            end else if ($urandom_range(0, 1999) == 0) begin
                off_cnt = $urandom_range(1, 40);
                en = 0;
            end
            reset = (c == rst_at) || (c == rst_at + 1);
            step();
        end
        reset = 0;
        s_valid = 0;
        underrun_clr = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
